// File: rtl/hid_report_capture_if.sv
// Bundle between report sources/display consumers and hid_report_capture.
// master drives the report strobes and display controls; slave is the capture stage.
interface hid_report_capture_if #(
  parameter int C_channels    = 3,
  parameter int C_report_bits = 64,
  parameter int C_hist_depth  = 8
);
  localparam int C_idx_bits = $clog2(C_hist_depth);

  logic [C_channels*C_report_bits-1:0] report_i;
  logic [C_channels-1:0]               valid_i;
  logic                                mode_i;
  logic [2:0]                          sel_i;
  logic                                freeze_i;
  logic                                ack_i;
  logic [C_idx_bits-1:0]               hist_idx_i;
  logic [C_report_bits-1:0]            display_o;
  logic [2:0]                          display_ch_o;
  logic [C_channels-1:0]               changed_o;
  logic [C_channels*8-1:0]             count_o;
  logic [C_report_bits-1:0]            hist_o;
  logic [2:0]                          hist_ch_o;
  logic [C_idx_bits:0]                 hist_fill_o;
  logic [7:0]                          dropped_o;

  modport master (
    output report_i, valid_i, mode_i, sel_i, freeze_i, ack_i, hist_idx_i,
    input  display_o, display_ch_o, changed_o, count_o, hist_o, hist_ch_o,
           hist_fill_o, dropped_o
  );

  modport slave (
    input  report_i, valid_i, mode_i, sel_i, freeze_i, ack_i, hist_idx_i,
    output display_o, display_ch_o, changed_o, count_o, hist_o, hist_ch_o,
           hist_fill_o, dropped_o
  );
endinterface

// File: rtl/hid_report_capture.sv
// Multi-channel HID report capture: per-channel latch/counter/change flag, tagged history ring,
// fixed or auto-rotating display with freeze. Macro HID_CAPTURE_FILTER_EN ignores repeated reports.
module hid_report_capture #(
  parameter int C_channels      = 3,
  parameter int C_report_bits   = 64,
  parameter int C_hist_depth    = 8,
  parameter int C_rotate_cycles = 25000000
) (
  input logic clk_i,
  input logic rstn_i,
  hid_report_capture_if.slave bus
);
  localparam int C_idx_bits = $clog2(C_hist_depth);
  localparam int C_tmr_bits = $clog2(C_rotate_cycles);
  localparam logic [2:0] C_last_ch = 3'(C_channels - 1);
  localparam logic [C_tmr_bits-1:0] C_tmr_last = C_tmr_bits'(C_rotate_cycles - 1);
  localparam logic [C_idx_bits:0] C_fill_max = (C_idx_bits + 1)'(C_hist_depth);

  function automatic logic [3:0] pop_count(input logic [C_channels-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < C_channels; k++) begin
      n = n + {3'd0, v[k]};
    end
    return n;
  endfunction

  logic [C_report_bits-1:0] latch_r [C_channels];
  logic [7:0]               cnt_r [C_channels];
  logic [C_channels-1:0]    changed_r;
  logic [C_channels-1:0]    cap_s;

  logic [C_report_bits-1:0] hist_mem_r [C_hist_depth];
  logic [2:0]               hist_tag_r [C_hist_depth];
  logic [C_idx_bits-1:0]    wptr_r;
  logic [C_idx_bits:0]      fill_r;
  logic [7:0]               dropped_r;
  logic [C_idx_bits-1:0]    rd_ptr_s;

  logic [C_report_bits-1:0] first_rep_s;
  logic [2:0]               first_ch_s;
  logic [3:0]               pop_s;
  logic [8:0]               drop_sum_s;
  logic [7:0]               dropped_nxt_s;

  logic [2:0]               fixed_ch_s;
  logic [2:0]               sel_ch_s;
  logic [2:0]               rot_ch_r;
  logic [C_tmr_bits-1:0]    tmr_r;
  logic [C_report_bits-1:0] disp_sel_s;
  logic [C_report_bits-1:0] display_r;
  logic [2:0]               display_ch_r;

  // Decide which strobes actually capture this cycle.
  always_comb begin
    cap_s = '0;
    for (int k = 0; k < C_channels; k++) begin
`ifdef HID_CAPTURE_FILTER_EN
      cap_s[k] = bus.valid_i[k] &&
                 (bus.report_i[k*C_report_bits +: C_report_bits] != latch_r[k]);
`else
      cap_s[k] = bus.valid_i[k];
`endif
    end
  end

  // Lowest-indexed capture goes to history; every extra one is a collision.
  always_comb begin
    first_rep_s = '0;
    first_ch_s  = 3'd0;
    for (int k = C_channels - 1; k >= 0; k--) begin
      if (cap_s[k]) begin
        first_rep_s = bus.report_i[k*C_report_bits +: C_report_bits];
        first_ch_s  = 3'(k);
      end else begin
        first_rep_s = first_rep_s;
        first_ch_s  = first_ch_s;
      end
    end
    pop_s = pop_count(cap_s);
    if (pop_s > 4'd1) begin
      drop_sum_s = {1'b0, dropped_r} + {5'd0, pop_s - 4'd1};
    end else begin
      drop_sum_s = {1'b0, dropped_r};
    end
    if (drop_sum_s > 9'd255) begin
      dropped_nxt_s = 8'd255;
    end else begin
      dropped_nxt_s = drop_sum_s[7:0];
    end
  end

  // Channel selection and latch mux feeding the display register.
  always_comb begin
    if (bus.sel_i > C_last_ch) begin
      fixed_ch_s = C_last_ch;
    end else begin
      fixed_ch_s = bus.sel_i;
    end
    if (bus.mode_i) begin
      sel_ch_s = rot_ch_r;
    end else begin
      sel_ch_s = fixed_ch_s;
    end
    disp_sel_s = '0;
    for (int k = 0; k < C_channels; k++) begin
      if (sel_ch_s == 3'(k)) begin
        disp_sel_s = latch_r[k];
      end else begin
        disp_sel_s = disp_sel_s;
      end
    end
  end

  // Per-channel latch, counter and sticky change flag; a capture beats an ack.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < C_channels; k++) begin
        latch_r[k] <= '0;
        cnt_r[k]   <= 8'd0;
      end
      changed_r <= '0;
    end else begin
      for (int k = 0; k < C_channels; k++) begin
        if (cap_s[k]) begin
          latch_r[k]   <= bus.report_i[k*C_report_bits +: C_report_bits];
          cnt_r[k]     <= cnt_r[k] + 8'd1;
          changed_r[k] <= 1'b1;
        end else if (bus.ack_i && (display_ch_r == 3'(k))) begin
          changed_r[k] <= 1'b0;
        end else begin
          changed_r[k] <= changed_r[k];
        end
      end
    end
  end

  // History ring write, fill level and saturating collision counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < C_hist_depth; i++) begin
        hist_mem_r[i] <= '0;
        hist_tag_r[i] <= 3'd0;
      end
      wptr_r    <= '0;
      fill_r    <= '0;
      dropped_r <= 8'd0;
    end else if (|cap_s) begin
      hist_mem_r[wptr_r] <= first_rep_s;
      hist_tag_r[wptr_r] <= first_ch_s;
      wptr_r             <= wptr_r + C_idx_bits'(1);
      dropped_r          <= dropped_nxt_s;
      if (fill_r != C_fill_max) begin
        fill_r <= fill_r + (C_idx_bits + 1)'(1);
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      wptr_r    <= wptr_r;
      fill_r    <= fill_r;
      dropped_r <= dropped_r;
    end
  end

  // Rotate timer and display registers; freeze holds both. In fixed mode the
  // rotate channel shadows the selection so rotation starts where the display is.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmr_r        <= '0;
      rot_ch_r     <= 3'd0;
      display_r    <= '0;
      display_ch_r <= 3'd0;
    end else if (!bus.freeze_i) begin
      display_r    <= disp_sel_s;
      display_ch_r <= sel_ch_s;
      if (!bus.mode_i) begin
        tmr_r    <= '0;
        rot_ch_r <= fixed_ch_s;
      end else if (tmr_r == C_tmr_last) begin
        tmr_r <= '0;
        if (rot_ch_r >= C_last_ch) begin
          rot_ch_r <= 3'd0;
        end else begin
          rot_ch_r <= rot_ch_r + 3'd1;
        end
      end else begin
        tmr_r <= tmr_r + C_tmr_bits'(1);
      end
    end else begin
      if (!bus.mode_i) begin
        tmr_r <= '0;
      end else begin
        tmr_r <= tmr_r;
      end
    end
  end

  // Combinational history read, newest first; unfilled slots read as zero.
  always_comb begin
    rd_ptr_s = wptr_r - C_idx_bits'(1) - bus.hist_idx_i;
    if ({1'b0, bus.hist_idx_i} >= fill_r) begin
      bus.hist_o    = '0;
      bus.hist_ch_o = 3'd0;
    end else begin
      bus.hist_o    = hist_mem_r[rd_ptr_s];
      bus.hist_ch_o = hist_tag_r[rd_ptr_s];
    end
  end

  // Flatten per-channel counters onto the output bus.
  always_comb begin
    bus.count_o = '0;
    for (int k = 0; k < C_channels; k++) begin
      bus.count_o[k*8 +: 8] = cnt_r[k];
    end
  end

  assign bus.display_o    = display_r;
  assign bus.display_ch_o = display_ch_r;
  assign bus.changed_o    = changed_r;
  assign bus.hist_fill_o  = fill_r;
  assign bus.dropped_o    = dropped_r;
endmodule

// File: tb/tb_hid_report_capture.sv
// Directed self-checking bench for hid_report_capture (3 channels, 64-bit, depth 8, dwell 4).
`timescale 1ns/1ps
module tb_hid_report_capture;
  localparam int C_CH = 3;
  localparam int C_RB = 64;
  localparam int C_HD = 8;
  localparam int C_RC = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hid_report_capture_if #(.C_channels(C_CH), .C_report_bits(C_RB), .C_hist_depth(C_HD)) bus ();

  hid_report_capture #(
    .C_channels(C_CH), .C_report_bits(C_RB), .C_hist_depth(C_HD), .C_rotate_cycles(C_RC)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [63:0] v);
    bus.report_i[ch*C_RB +: C_RB] = v;
    bus.valid_i = 3'(1 << ch);
    tick();
    bus.valid_i = 3'b000;
  endtask

  task automatic test_reset();
    bus.report_i = '0; bus.valid_i = 3'b000; bus.mode_i = 1'b0; bus.sel_i = 3'd0;
    bus.freeze_i = 1'b0; bus.ack_i = 1'b0; bus.hist_idx_i = 3'd0;
    rstn = 1'b0;
    tick(); tick();
    n_checks++; if (bus.display_o !== 64'd0) begin n_fail++; $display("FAIL reset_display got %h want 0", bus.display_o); end
    n_checks++; if (bus.count_o !== 24'd0 || bus.changed_o !== 3'b000) begin n_fail++; $display("FAIL reset_count_changed got %h/%b want 0/000", bus.count_o, bus.changed_o); end
    n_checks++; if (bus.hist_fill_o !== 4'd0 || bus.dropped_o !== 8'd0 || bus.display_ch_o !== 3'd0) begin n_fail++; $display("FAIL reset_hist got fill %0d drop %0d ch %0d want 0", bus.hist_fill_o, bus.dropped_o, bus.display_ch_o); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    send(0, 64'h0123456789ABCDEF);
    n_checks++; if (bus.count_o[7:0] !== 8'd1) begin n_fail++; $display("FAIL cap_count got %0d want 1", bus.count_o[7:0]); end
    n_checks++; if (bus.changed_o !== 3'b001) begin n_fail++; $display("FAIL cap_changed got %b want 001", bus.changed_o); end
    n_checks++; if (bus.hist_fill_o !== 4'd1) begin n_fail++; $display("FAIL cap_fill got %0d want 1", bus.hist_fill_o); end
    n_checks++; if (bus.hist_o !== 64'h0123456789ABCDEF || bus.hist_ch_o !== 3'd0) begin n_fail++; $display("FAIL cap_hist got %h/%0d want 0123456789abcdef/0", bus.hist_o, bus.hist_ch_o); end
    n_checks++; if (bus.display_o !== 64'd0) begin n_fail++; $display("FAIL cap_display_early got %h want 0", bus.display_o); end
    tick();
    n_checks++; if (bus.display_o !== 64'h0123456789ABCDEF || bus.display_ch_o !== 3'd0) begin n_fail++; $display("FAIL cap_display got %h/%0d want 0123456789abcdef/0", bus.display_o, bus.display_ch_o); end
  endtask

  task automatic test_multi();
    bus.report_i[1*C_RB +: C_RB] = 64'h11;
    bus.report_i[2*C_RB +: C_RB] = 64'h22;
    bus.valid_i = 3'b110;
    tick();
    bus.valid_i = 3'b000;
    n_checks++; if (bus.count_o[15:8] !== 8'd1 || bus.count_o[23:16] !== 8'd1) begin n_fail++; $display("FAIL multi_counts got %0d/%0d want 1/1", bus.count_o[15:8], bus.count_o[23:16]); end
    n_checks++; if (bus.changed_o !== 3'b111) begin n_fail++; $display("FAIL multi_changed got %b want 111", bus.changed_o); end
    n_checks++; if (bus.hist_o !== 64'h11 || bus.hist_ch_o !== 3'd1) begin n_fail++; $display("FAIL multi_hist0 got %h/%0d want 11/1", bus.hist_o, bus.hist_ch_o); end
    n_checks++; if (bus.dropped_o !== 8'd1 || bus.hist_fill_o !== 4'd2) begin n_fail++; $display("FAIL multi_drop_fill got %0d/%0d want 1/2", bus.dropped_o, bus.hist_fill_o); end
    bus.hist_idx_i = 3'd1; #1;
    n_checks++; if (bus.hist_o !== 64'h0123456789ABCDEF || bus.hist_ch_o !== 3'd0) begin n_fail++; $display("FAIL multi_hist1 got %h/%0d want 0123456789abcdef/0", bus.hist_o, bus.hist_ch_o); end
    bus.hist_idx_i = 3'd2; #1;
    n_checks++; if (bus.hist_o !== 64'd0 || bus.hist_ch_o !== 3'd0) begin n_fail++; $display("FAIL multi_hist_empty got %h/%0d want 0/0", bus.hist_o, bus.hist_ch_o); end
    bus.hist_idx_i = 3'd0;
    bus.sel_i = 3'd2; tick();
    n_checks++; if (bus.display_o !== 64'h22 || bus.display_ch_o !== 3'd2) begin n_fail++; $display("FAIL sel2 got %h/%0d want 22/2", bus.display_o, bus.display_ch_o); end
    bus.sel_i = 3'd7; tick();
    n_checks++; if (bus.display_ch_o !== 3'd2) begin n_fail++; $display("FAIL sel_clamp got %0d want 2", bus.display_ch_o); end
    bus.sel_i = 3'd1; tick();
    n_checks++; if (bus.display_o !== 64'h11 || bus.display_ch_o !== 3'd1) begin n_fail++; $display("FAIL sel1 got %h/%0d want 11/1", bus.display_o, bus.display_ch_o); end
  endtask

  task automatic test_ack();
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    n_checks++; if (bus.changed_o !== 3'b101) begin n_fail++; $display("FAIL ack_clear got %b want 101", bus.changed_o); end
    send(1, 64'h33);
    n_checks++; if (bus.changed_o !== 3'b111 || bus.count_o[15:8] !== 8'd2) begin n_fail++; $display("FAIL ack_reset_flag got %b/%0d want 111/2", bus.changed_o, bus.count_o[15:8]); end
    bus.ack_i = 1'b1; send(1, 64'h44); bus.ack_i = 1'b0;
    n_checks++; if (bus.changed_o !== 3'b111 || bus.count_o[15:8] !== 8'd3) begin n_fail++; $display("FAIL ack_vs_valid got %b/%0d want 111/3", bus.changed_o, bus.count_o[15:8]); end
  endtask

  task automatic test_rotate();
    logic [2:0]  exp_ch [4];
    logic [63:0] exp_d [4];
    exp_ch[0] = 3'd0; exp_ch[1] = 3'd1; exp_ch[2] = 3'd2; exp_ch[3] = 3'd0;
    exp_d[0] = 64'h0123456789ABCDEF; exp_d[1] = 64'h44; exp_d[2] = 64'h22; exp_d[3] = 64'h0123456789ABCDEF;
    bus.sel_i = 3'd0; tick();
    bus.mode_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick(); tick(); tick(); tick();
      n_checks++; if (bus.display_ch_o !== exp_ch[g] || bus.display_o !== exp_d[g]) begin n_fail++; $display("FAIL rotate_step%0d got %0d/%h want %0d/%h", g, bus.display_ch_o, bus.display_o, exp_ch[g], exp_d[g]); end
    end
    bus.freeze_i = 1'b1;
    send(0, 64'hAA);
    for (int i = 0; i < 9; i++) tick();
    n_checks++; if (bus.display_ch_o !== 3'd0 || bus.display_o !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL freeze_hold got %0d/%h want 0/0123456789abcdef", bus.display_ch_o, bus.display_o); end
    n_checks++; if (bus.count_o[7:0] !== 8'd2) begin n_fail++; $display("FAIL freeze_count got %0d want 2", bus.count_o[7:0]); end
    bus.freeze_i = 1'b0; tick();
    n_checks++; if (bus.display_ch_o !== 3'd1 || bus.display_o !== 64'h44) begin n_fail++; $display("FAIL freeze_release got %0d/%h want 1/44", bus.display_ch_o, bus.display_o); end
    tick(); tick(); tick(); tick();
    n_checks++; if (bus.display_ch_o !== 3'd2 || bus.display_o !== 64'h22) begin n_fail++; $display("FAIL rotate_resume got %0d/%h want 2/22", bus.display_ch_o, bus.display_o); end
    bus.mode_i = 1'b0; tick();
  endtask

  task automatic test_hist_wrap();
    for (int i = 1; i <= 9; i++) send(0, 64'h100 + 64'(i));
    n_checks++; if (bus.hist_fill_o !== 4'd8) begin n_fail++; $display("FAIL wrap_fill got %0d want 8", bus.hist_fill_o); end
    bus.hist_idx_i = 3'd0; #1;
    n_checks++; if (bus.hist_o !== 64'h109 || bus.hist_ch_o !== 3'd0) begin n_fail++; $display("FAIL wrap_idx0 got %h/%0d want 109/0", bus.hist_o, bus.hist_ch_o); end
    bus.hist_idx_i = 3'd7; #1;
    n_checks++; if (bus.hist_o !== 64'h102) begin n_fail++; $display("FAIL wrap_idx7 got %h want 102", bus.hist_o); end
    bus.hist_idx_i = 3'd0;
    n_checks++; if (bus.count_o[7:0] !== 8'd11) begin n_fail++; $display("FAIL wrap_count11 got %0d want 11", bus.count_o[7:0]); end
    for (int i = 0; i < 245; i++) send(0, 64'h1000 + 64'(i));
    n_checks++; if (bus.count_o[7:0] !== 8'd0 || bus.changed_o[0] !== 1'b1) begin n_fail++; $display("FAIL count_wrap got %0d/%b want 0/1", bus.count_o[7:0], bus.changed_o[0]); end
    n_checks++; if (bus.dropped_o !== 8'd1 || bus.hist_fill_o !== 4'd8) begin n_fail++; $display("FAIL wrap_drop_fill got %0d/%0d want 1/8", bus.dropped_o, bus.hist_fill_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_cnt;
    logic [63:0] exp_h1;
    logic [7:0]  exp_c2;
`ifdef HID_CAPTURE_FILTER_EN
    exp_cnt = 8'd1; exp_h1 = 64'h10F4; exp_c2 = 8'd1;
`else
    exp_cnt = 8'd2; exp_h1 = 64'h55; exp_c2 = 8'd2;
`endif
    send(0, 64'h55);
    send(0, 64'h55);
    n_checks++; if (bus.count_o[7:0] !== exp_cnt) begin n_fail++; $display("FAIL repeat_count got %0d want %0d", bus.count_o[7:0], exp_cnt); end
    bus.hist_idx_i = 3'd0; #1;
    n_checks++; if (bus.hist_o !== 64'h55) begin n_fail++; $display("FAIL repeat_hist0 got %h want 55", bus.hist_o); end
    bus.hist_idx_i = 3'd1; #1;
    n_checks++; if (bus.hist_o !== exp_h1) begin n_fail++; $display("FAIL repeat_hist1 got %h want %h", bus.hist_o, exp_h1); end
    bus.hist_idx_i = 3'd0;
    send(2, 64'h22);
    n_checks++; if (bus.count_o[23:16] !== exp_c2) begin n_fail++; $display("FAIL repeat_ch2 got %0d want %0d", bus.count_o[23:16], exp_c2); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #2;
    rstn = 1'b0; #1;
    n_checks++; if (bus.count_o !== 24'd0 || bus.changed_o !== 3'b000 || bus.display_o !== 64'd0) begin n_fail++; $display("FAIL midreset_state got %h/%b/%h want 0", bus.count_o, bus.changed_o, bus.display_o); end
    n_checks++; if (bus.hist_fill_o !== 4'd0 || bus.dropped_o !== 8'd0 || bus.hist_o !== 64'd0) begin n_fail++; $display("FAIL midreset_hist got %0d/%0d/%h want 0", bus.hist_fill_o, bus.dropped_o, bus.hist_o); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_multi();
    test_ack();
    test_rotate();
    test_hist_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
